// File: rtl/final_image_pkg.sv
// final_image_pkg
// Shared definitions for the final image frame store: default geometry
// constants and the fill/drain state type used by final_image_buffer.
package final_image_pkg;

  localparam int unsigned FIB_DATA_W = 8;
  localparam int unsigned FIB_DEPTH  = 256;
  localparam int unsigned FIB_ADDR_W = 8;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fib_state_t;

endpackage

// File: rtl/final_image_ram.sv
// final_image_ram
// Simple dual-port frame memory: one write port, one synchronous read port
// with 1-cycle latency. No reset on the array or read register so the
// storage maps onto block RAM.
//   clk : clock
//   we  : write enable       wa : write address     wd : write data
//   re  : read enable        ra : read address      rd : registered read data
module final_image_ram #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [IDX_W-1:0]  ra,
  output logic [DATA_W-1:0] rd
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    if (re) rd <= mem[ra];
  end

endmodule

// File: rtl/final_image_buffer.sv
// final_image_buffer
// Frame store at the tail of the output path. Pixels arrive through a
// random-access write port; once every address has been written the frame
// is streamed out in address order over a valid/ready interface.
//   CLK, RST_N              : clock, asynchronous active-low reset
//   CLEAR                   : synchronous flush back to FILL
//   WE, WA, WD              : pixel write port
//   OUT_VALID/READY/DATA/LAST : output stream, LAST on index DEPTH-1
//   BUSY                    : high while draining
//   FRAME_DONE              : one-cycle pulse after the last beat
//   FILL_COUNT              : distinct addresses written this frame
//   ERR_ADDR, ERR_OVERRUN   : sticky write-error flags
module final_image_buffer
  import final_image_pkg::*;
#(
  parameter int unsigned DATA_W = FIB_DATA_W,
  parameter int unsigned DEPTH  = FIB_DEPTH,
  parameter int unsigned ADDR_W = FIB_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CLEAR,
  input  logic              WE,
  input  logic [ADDR_W-1:0] WA,
  input  logic [DATA_W-1:0] WD,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] OUT_DATA,
  output logic              OUT_LAST,
  output logic              BUSY,
  output logic              FRAME_DONE,
  output logic [ADDR_W:0]   FILL_COUNT,
  output logic              ERR_ADDR,
  output logic              ERR_OVERRUN
);

  localparam int unsigned     IDX_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_C  = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

  fib_state_t        state_q, state_d;
  logic [DEPTH-1:0]  valid_q;
  logic [ADDR_W:0]   fill_count_q;
  logic [ADDR_W:0]   rd_ptr_q;
  logic              pend_q, pend_last_q;
  logic              out_valid_q, out_last_q;
  logic [DATA_W-1:0] out_data_q;
  logic              skid_valid_q, skid_last_q;
  logic [DATA_W-1:0] skid_data_q;
  logic              err_addr_q, err_overrun_q;
  logic [DATA_W-1:0] ram_rd;

  logic              wa_in_range;
  logic [IDX_W-1:0]  wa_idx;
  logic              fill_wr;
  logic              new_px;
  logic              xfer;
  logic              last_xfer;
  logic [2:0]        occ;
  logic              rd_issue;

  always_comb begin
    wa_in_range = ({1'b0, WA} < DEPTH_C);
    wa_idx      = WA[IDX_W-1:0];
    fill_wr     = (state_q == FILL) && WE && wa_in_range && !CLEAR;
    new_px      = fill_wr && !valid_q[wa_idx];
    xfer        = out_valid_q && OUT_READY;
    last_xfer   = xfer && out_last_q;
    // Beats held or in flight once this cycle's transfer is retired; a new
    // read is only issued if the output+skid pair can still absorb it.
    occ         = {2'b0, out_valid_q} + {2'b0, skid_valid_q} + {2'b0, pend_q}
                - {2'b0, xfer};
    rd_issue    = (state_q == DRAIN) && (rd_ptr_q < DEPTH_C) && (occ < 3'd2);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:    if (fill_count_q == DEPTH_C) state_d = DRAIN;
      DRAIN:   if (last_xfer) state_d = DONE;
      DONE:    state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  final_image_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_ram (
    .clk (CLK),
    .we  (fill_wr),
    .wa  (wa_idx),
    .wd  (WD),
    .re  (rd_issue),
    .ra  (rd_ptr_q[IDX_W-1:0]),
    .rd  (ram_rd)
  );

  // FSM, fill bookkeeping and error flags
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q       <= FILL;
      valid_q       <= '0;
      fill_count_q  <= '0;
      rd_ptr_q      <= '0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      err_addr_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else if (CLEAR) begin
      state_q       <= FILL;
      valid_q       <= '0;
      fill_count_q  <= '0;
      rd_ptr_q      <= '0;
      pend_q        <= 1'b0;
      pend_last_q   <= 1'b0;
      err_addr_q    <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (fill_wr) valid_q[wa_idx] <= 1'b1;
      if (new_px) fill_count_q <= fill_count_q + ONE_C;
      if (WE && (state_q == FILL) && !wa_in_range) err_addr_q <= 1'b1;
      if (WE && (state_q != FILL)) err_overrun_q <= 1'b1;
      if (rd_issue) rd_ptr_q <= rd_ptr_q + ONE_C;
      if (state_q == DONE) begin
        valid_q      <= '0;
        fill_count_q <= '0;
        rd_ptr_q     <= '0;
      end
      pend_q      <= rd_issue;
      pend_last_q <= rd_issue && (rd_ptr_q == LAST_C);
    end
  end

  // Output register with a one-entry skid behind it: RAM data lands in the
  // output register when it is free, otherwise in the skid entry.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
    end else if (CLEAR) begin
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_last_q  <= 1'b0;
    end else if (!out_valid_q || OUT_READY) begin
      if (skid_valid_q) begin
        out_valid_q  <= 1'b1;
        out_data_q   <= skid_data_q;
        out_last_q   <= skid_last_q;
        skid_valid_q <= pend_q;
        skid_data_q  <= ram_rd;
        skid_last_q  <= pend_last_q;
      end else if (pend_q) begin
        out_valid_q <= 1'b1;
        out_data_q  <= ram_rd;
        out_last_q  <= pend_last_q;
      end else begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end
    end else if (pend_q) begin
      skid_valid_q <= 1'b1;
      skid_data_q  <= ram_rd;
      skid_last_q  <= pend_last_q;
    end
  end

  assign OUT_VALID   = out_valid_q;
  assign OUT_DATA    = out_data_q;
  assign OUT_LAST    = out_last_q;
  assign BUSY        = (state_q == DRAIN);
  assign FRAME_DONE  = (state_q == DONE);
  assign FILL_COUNT  = fill_count_q;
  assign ERR_ADDR    = err_addr_q;
  assign ERR_OVERRUN = err_overrun_q;

endmodule

// File: tb/tb_final_image_buffer.sv
// tb_final_image_buffer
// Self-checking bench for final_image_buffer. A DEPTH=4 instance covers the
// directed scenarios, a DEPTH=256 instance covers back-to-back random frames.
// A shared stimulus bus drives whichever instance `sel` points at; a
// behavioural frame model (array + valid map + count) predicts every output.
module tb_final_image_buffer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, clear, we, ready, sel;
  logic [7:0] wa, wd;

  logic       s_we, b_we;
  logic [2:0] s_wa;
  assign s_we = we & ~sel;
  assign b_we = we & sel;
  assign s_wa = wa[2:0];

  logic       s_ov, s_ol, s_busy, s_fd, s_ea, s_eo;
  logic [7:0] s_od;
  logic [3:0] s_cnt;
  logic       b_ov, b_ol, b_busy, b_fd, b_ea, b_eo;
  logic [7:0] b_od;
  logic [8:0] b_cnt;

  final_image_buffer #(.DATA_W(8), .DEPTH(4), .ADDR_W(3)) u_small (
    .CLK(clk), .RST_N(rst_n), .CLEAR(clear), .WE(s_we), .WA(s_wa), .WD(wd),
    .OUT_VALID(s_ov), .OUT_READY(ready), .OUT_DATA(s_od), .OUT_LAST(s_ol),
    .BUSY(s_busy), .FRAME_DONE(s_fd), .FILL_COUNT(s_cnt),
    .ERR_ADDR(s_ea), .ERR_OVERRUN(s_eo)
  );

  final_image_buffer #(.DATA_W(8), .DEPTH(256), .ADDR_W(8)) u_big (
    .CLK(clk), .RST_N(rst_n), .CLEAR(clear), .WE(b_we), .WA(wa), .WD(wd),
    .OUT_VALID(b_ov), .OUT_READY(ready), .OUT_DATA(b_od), .OUT_LAST(b_ol),
    .BUSY(b_busy), .FRAME_DONE(b_fd), .FILL_COUNT(b_cnt),
    .ERR_ADDR(b_ea), .ERR_OVERRUN(b_eo)
  );

  logic       ov, ol, busy, fdone, erra, erro;
  logic [7:0] od;
  logic [8:0] cnt;
  always_comb begin
    if (sel) begin
      ov = b_ov; ol = b_ol; busy = b_busy; fdone = b_fd; erra = b_ea; erro = b_eo;
      od = b_od; cnt = b_cnt;
    end else begin
      ov = s_ov; ol = s_ol; busy = s_busy; fdone = s_fd; erra = s_ea; erro = s_eo;
      od = s_od; cnt = {5'b0, s_cnt};
    end
  end

  int         total = 0;
  int         bad = 0;
  int         fd_seen = 0;
  int         depth;
  int         mcount;
  int         fd0;
  logic [7:0] mmem [256];
  bit         mval [256];

  always @(negedge clk) if (fdone) fd_seen++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 256; i++) mval[i] = 1'b0;
    mcount = 0;
  endtask

  task automatic write_px(input int a, input logic [7:0] d);
    wa = a[7:0];
    wd = d;
    we = 1'b1;
    step();
    we = 1'b0;
    if (a < depth) begin
      mmem[a] = d;
      if (!mval[a]) begin
        mval[a] = 1'b1;
        mcount++;
      end
    end
    check_eq("fill_count", cnt, mcount);
  endtask

  task automatic fill_perm();
    int order [256];
    int j, t;
    for (int i = 0; i < depth; i++) order[i] = i;
    for (int i = depth - 1; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = order[i]; order[i] = order[j]; order[j] = t;
    end
    for (int i = 0; i < depth; i++) write_px(order[i], 8'($urandom_range(0, 255)));
    check_eq("pre_drain_fill", busy, 0);
  endtask

  task automatic fill_random();
    int n;
    n = 0;
    while (mcount < depth && n < 20000) begin
      write_px($urandom_range(0, depth - 1), 8'($urandom));
      n++;
    end
    check_eq("fill_full", cnt, depth);
    check_eq("pre_drain_fill", busy, 0);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0, 2: random ready
  task automatic drain_frame(input int mode, input int abort_at, input bit inject);
    int         idx, c;
    bit         held, injected;
    logic [7:0] hd;
    logic       hl;
    idx = 0; c = 0; held = 0; injected = 0; hd = '0; hl = 1'b0;
    step();
    check_eq("enter_drain_busy", busy, 1);
    check_eq("enter_drain_valid", ov, 0);
    step();
    check_eq("read_latency_valid", ov, 0);
    step();
    check_eq("first_valid", ov, 1);
    while (idx < depth && c < 8 * depth + 32) begin
      case (mode)
        0:       ready = 1'b1;
        1:       ready = (c % 3 == 0);
        default: ready = 1'($urandom_range(0, 1));
      endcase
      if (inject && idx == 1 && !injected) begin
        we = 1'b1; wa = 8'h00; wd = 8'hEE; injected = 1'b1;
      end
      if (held) begin
        check_eq("stall_valid", ov, 1);
        check_eq("stall_data", od, hd);
        check_eq("stall_last", ol, hl);
      end
      if (mode == 0) check_eq("no_bubble", ov, 1);
      held = 1'b0;
      if (ov && ready) begin
        check_eq("beat_data", od, mmem[idx]);
        check_eq("beat_last", ol, (idx == depth - 1) ? 1 : 0);
        idx++;
      end else if (ov) begin
        held = 1'b1; hd = od; hl = ol;
      end
      step();
      we = 1'b0;
      c++;
      if (abort_at > 0 && idx == abort_at) break;
    end
    ready = 1'b0;
    if (abort_at > 0) begin
      check_eq("abort_point_valid", ov, 1);
      return;
    end
    check_eq("drain_complete", idx, depth);
    check_eq("frame_done_pulse", fdone, 1);
    check_eq("done_valid", ov, 0);
    step();
    check_eq("frame_done_end", fdone, 0);
    check_eq("count_cleared", cnt, 0);
    check_eq("back_to_fill", busy, 0);
    clear_model();
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0; we = 1'b0; ready = 1'b0;
    wa = '0; wd = '0; sel = 1'b0; depth = 4;
    clear_model();
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    step(); step();
    check_eq("rst_valid", ov, 0);
    check_eq("rst_data", od, 0);
    check_eq("rst_last", ol, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", fdone, 0);
    check_eq("rst_count", cnt, 0);
    check_eq("rst_err_addr", erra, 0);
    check_eq("rst_err_overrun", erro, 0);
    sel = 1'b1;
    check_eq("rst_big_count", cnt, 0);
    check_eq("rst_big_valid", ov, 0);
    sel = 1'b0;
    rst_n = 1'b1;
    step();

    // out-of-order fill, full-rate drain
    write_px(3, 8'hA3); write_px(1, 8'hA1); write_px(0, 8'hA0); write_px(2, 8'hA2);
    check_eq("t1_pre_drain", busy, 0);
    fd0 = fd_seen;
    drain_frame(0, 0, 0);
    check_eq("t1_done_once", fd_seen - fd0, 1);

    // rewrite of one address, stalled drain
    write_px(1, 8'h11); write_px(1, 8'h22);
    write_px(0, 8'h30); write_px(2, 8'h32); write_px(3, 8'h33);
    check_eq("t2_pre_drain", busy, 0);
    drain_frame(1, 0, 0);

    // error flags
    write_px(0, 8'h5A);
    write_px(4, 8'h55);
    check_eq("err_addr_set", erra, 1);
    check_eq("err_overrun_clear", erro, 0);
    write_px(5, 8'h66);
    write_px(1, 8'h61); write_px(2, 8'h62); write_px(3, 8'h63);
    drain_frame(2, 0, 1);
    check_eq("err_addr_sticky", erra, 1);
    check_eq("err_overrun_set", erro, 1);
    clear = 1'b1; we = 1'b1; wa = 8'h00; wd = 8'hFF;
    step();
    clear = 1'b0; we = 1'b0;
    check_eq("clear_err_addr", erra, 0);
    check_eq("clear_err_overrun", erro, 0);
    check_eq("clear_count", cnt, 0);
    clear_model();

    // CLEAR mid-drain
    fill_perm();
    drain_frame(0, 2, 0);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_eq("clear_abort_valid", ov, 0);
    check_eq("clear_abort_count", cnt, 0);
    check_eq("clear_abort_busy", busy, 0);
    check_eq("clear_abort_done", fdone, 0);
    clear_model();
    fill_perm();
    drain_frame(0, 0, 0);

    // reset mid-drain
    fill_perm();
    drain_frame(0, 2, 0);
    rst_n = 1'b0;
    #1;
    check_eq("reset_abort_valid", ov, 0);
    check_eq("reset_abort_count", cnt, 0);
    check_eq("reset_abort_busy", busy, 0);
    step();
    rst_n = 1'b1;
    step();
    clear_model();
    fill_perm();
    drain_frame(2, 0, 0);

    // back-to-back random frames on the full-size store
    sel = 1'b1;
    depth = 256;
    clear_model();
    fd0 = fd_seen;
    fill_random();
    drain_frame(2, 0, 0);
    fill_random();
    drain_frame(0, 0, 0);
    check_eq("big_done_twice", fd_seen - fd0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
